// File: rtl/mem_stage_bh_if.sv
// M-stage request bus and M/W register outputs of the memory stage.
// The master drives the E/M side and observes the W side. The slave is the stage itself.
interface mem_stage_bh_if;
    logic        valid_m;
    logic [31:0] instr_m;
    logic [31:0] pc_m;
    logic [4:0]  a3_m;
    logic [31:0] alu_out_m;
    logic [31:0] fwd_m;
    logic        stall_m;

    logic        valid_w;
    logic [31:0] instr_w;
    logic [31:0] pc_w;
    logic [4:0]  a3_w;
    logic [31:0] alu_out_w;
    logic [31:0] dm_read_w;
    logic [4:0]  exc_w;
    logic        we_pulse;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_byte_en;
    logic [31:0] w_pc;

    modport master (
        output valid_m, instr_m, pc_m, a3_m, alu_out_m, fwd_m,
        input  stall_m,
        input  valid_w, instr_w, pc_w, a3_w, alu_out_w, dm_read_w, exc_w,
        input  we_pulse, w_addr, w_data, w_byte_en, w_pc
    );

    modport slave (
        input  valid_m, instr_m, pc_m, a3_m, alu_out_m, fwd_m,
        output stall_m,
        output valid_w, instr_w, pc_w, a3_w, alu_out_w, dm_read_w, exc_w,
        output we_pulse, w_addr, w_data, w_byte_en, w_pc
    );
endinterface

// File: rtl/mem_stage_bh.sv
// MIPS M-stage: byte/half/word loads and stores, fault detection, M/W register.
// Latency LAT cycles for legal memory ops, 1 otherwise; stall_m holds upstream LAT-1 cycles.
module mem_stage_bh #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_stage_bh_if.slave  bus
);
    localparam int WORDS = 1 << ADDR_W;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [2:0]  cnt;

    logic [5:0]  opc;
    logic        is_load;
    logic        is_store;
    logic        sign_ext;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [1:0]  lane;
    logic        misaligned;
    logic        out_of_range;
    logic        mem_op;
    logic        fault;
    logic        legal;
    logic        last;
    logic        complete;
    logic        busy;

    logic [ADDR_W-1:0] widx;
    logic [31:0]       rd_word;
    logic [31:0]       st_data;
    logic [3:0]        st_be;
    logic [31:0]       merged;
    logic [31:0]       ld_shift;
    logic [15:0]       ld_half;
    logic [31:0]       ld_val;
    logic              wr_en;

    logic [31:0] mem [WORDS];

    assign opc  = bus.instr_m[31:26];
    assign addr = bus.alu_out_m;
    assign lane = addr[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SZ_WORD;
        unique case (opc)
            6'b100011: begin is_load = 1'b1; size = SZ_WORD; end
            6'b100001: begin is_load = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
            6'b100101: begin is_load = 1'b1; size = SZ_HALF; end
            6'b100000: begin is_load = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
            6'b100100: begin is_load = 1'b1; size = SZ_BYTE; end
            6'b101011: begin is_store = 1'b1; size = SZ_WORD; end
            6'b101001: begin is_store = 1'b1; size = SZ_HALF; end
            6'b101000: begin is_store = 1'b1; size = SZ_BYTE; end
            default:   ;
        endcase
    end

    assign misaligned   = ((size == SZ_WORD) && (lane != 2'b00)) ||
                          ((size == SZ_HALF) && lane[0]);
    assign out_of_range = |addr[31:ADDR_W+2];
    assign mem_op       = bus.valid_m && (is_load || is_store);
    assign fault        = mem_op && (misaligned || out_of_range);
    assign legal        = mem_op && !fault;

    // With LAT = 1 every legal op completes straight out of IDLE.
    assign last     = (LAT <= 1) || ((state == ACCESS) && (cnt == 3'(LAT - 1)));
    assign complete = legal && last;
    assign busy     = legal && !last;
    assign wr_en    = complete && is_store;

    // Reset must drop the stall at once, even while the op is still presented.
    assign bus.stall_m = rst_n && busy;

    assign widx    = addr[ADDR_W+1:2];
    assign rd_word = mem[widx];

    always_comb begin
        st_data = bus.fwd_m;
        st_be   = 4'b1111;
        unique case (size)
            SZ_BYTE: begin
                st_data = {4{bus.fwd_m[7:0]}};
                st_be   = 4'b0001 << lane;
            end
            SZ_HALF: begin
                st_data = {2{bus.fwd_m[15:0]}};
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
                merged[8*b +: 8] = st_data[8*b +: 8];
            end
        end
    end

    assign ld_shift = rd_word >> {lane, 3'b000};
    assign ld_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_val = rd_word;
        unique case (size)
            SZ_BYTE: ld_val = sign_ext ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                       : {24'h000000, ld_shift[7:0]};
            SZ_HALF: ld_val = sign_ext ? {{16{ld_half[15]}}, ld_half}
                                       : {16'h0000, ld_half};
            default: ;
        endcase
    end

    // One flop word per memory location so reset can clear the whole array.
    for (genvar g = 0; g < WORDS; g++) begin : g_mem
        logic [31:0] word_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (wr_en && (widx == ADDR_W'(g))) begin
                word_q <= merged;
            end
        end
        assign mem[g] = word_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (legal && (LAT > 1)) begin
                        state <= ACCESS;
                        cnt   <= 3'd1;
                    end
                end
                ACCESS: begin
                    if (cnt == 3'(LAT - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_w   <= 1'b0;
            bus.instr_w   <= '0;
            bus.pc_w      <= '0;
            bus.a3_w      <= '0;
            bus.alu_out_w <= '0;
            bus.dm_read_w <= '0;
            bus.exc_w     <= '0;
            bus.we_pulse  <= 1'b0;
            bus.w_addr    <= '0;
            bus.w_data    <= '0;
            bus.w_byte_en <= '0;
            bus.w_pc      <= '0;
        end else begin
            bus.we_pulse <= 1'b0;
            if (busy) begin
                // Access still in flight: W sees a bubble.
                bus.valid_w   <= 1'b0;
                bus.instr_w   <= '0;
                bus.pc_w      <= '0;
                bus.a3_w      <= '0;
                bus.alu_out_w <= '0;
                bus.dm_read_w <= '0;
                bus.exc_w     <= '0;
            end else begin
                bus.valid_w   <= bus.valid_m;
                bus.instr_w   <= bus.instr_m;
                bus.pc_w      <= bus.pc_m;
                bus.a3_w      <= fault ? 5'd0 : bus.a3_m;
                bus.alu_out_w <= bus.alu_out_m;
                bus.dm_read_w <= (complete && is_load) ? ld_val : 32'h0;
                bus.exc_w     <= fault ? (is_store ? 5'd5 : 5'd4) : 5'd0;
            end
            if (wr_en) begin
                bus.we_pulse  <= 1'b1;
                bus.w_addr    <= {addr[31:2], 2'b00};
                bus.w_data    <= merged;
                bus.w_byte_en <= st_be;
                bus.w_pc      <= bus.pc_m;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_bh.sv
// Scoreboard bench for mem_stage_bh: three instances at LAT 1, 3 and 4.
// Driver pushes expected W records and store commits; negedge monitors pop and compare.
module tb_mem_stage_bh;
    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;
    always #5 clk = ~clk;

    mem_stage_bh_if if1 ();
    mem_stage_bh_if if3 ();
    mem_stage_bh_if if4 ();

    mem_stage_bh #(.ADDR_W(12), .LAT(1)) u1 (.clk(clk), .rst_n(rst_n),  .bus(if1.slave));
    mem_stage_bh #(.ADDR_W(6),  .LAT(3)) u3 (.clk(clk), .rst_n(rst_n),  .bus(if3.slave));
    mem_stage_bh #(.ADDR_W(6),  .LAT(4)) u4 (.clk(clk), .rst_n(rst4_n), .bus(if4.slave));

    typedef struct {
        logic [31:0] instr, pc, alu, dm;
        logic [4:0]  a3, exc;
    } wexp_t;
    typedef struct {
        logic [31:0] addr, data, pc;
        logic [3:0]  be;
    } sexp_t;

    wexp_t wq1[$], wq3[$], wq4[$];
    sexp_t sq1[$], sq3[$], sq4[$];
    wexp_t we1, we3, we4;
    sexp_t se1, se3, se4;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101, LB = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100, SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    localparam logic [5:0] ALU = 6'b000000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cmp_w(input string tag, input wexp_t e, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] a3,
                         input logic [31:0] dm, input logic [4:0] exc);
        chk({tag, "_instr_w"}, instr, e.instr);
        chk({tag, "_pc_w"}, pc, e.pc);
        chk({tag, "_alu_out_w"}, alu, e.alu);
        chk({tag, "_a3_w"}, {27'd0, a3}, {27'd0, e.a3});
        chk({tag, "_dm_read_w"}, dm, e.dm);
        chk({tag, "_exc_w"}, {27'd0, exc}, {27'd0, e.exc});
    endtask

    task automatic cmp_s(input string tag, input sexp_t e, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic [31:0] pc);
        chk({tag, "_w_addr"}, addr, e.addr);
        chk({tag, "_w_data"}, data, e.data);
        chk({tag, "_w_byte_en"}, {28'd0, be}, {28'd0, e.be});
        chk({tag, "_w_pc"}, pc, e.pc);
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=output_present expected=nothing_queued", name);
    endtask

    always @(negedge clk) begin
        if (if1.valid_w === 1'b1) begin
            if (wq1.size() == 0) unexpected("u1_valid_w");
            else begin
                we1 = wq1.pop_front();
                cmp_w("u1", we1, if1.instr_w, if1.pc_w, if1.alu_out_w, if1.a3_w, if1.dm_read_w, if1.exc_w);
            end
        end
        if (if1.we_pulse === 1'b1) begin
            if (sq1.size() == 0) unexpected("u1_we_pulse");
            else begin
                se1 = sq1.pop_front();
                cmp_s("u1", se1, if1.w_addr, if1.w_data, if1.w_byte_en, if1.w_pc);
            end
        end
    end

    always @(negedge clk) begin
        if (if3.valid_w === 1'b1) begin
            if (wq3.size() == 0) unexpected("u3_valid_w");
            else begin
                we3 = wq3.pop_front();
                cmp_w("u3", we3, if3.instr_w, if3.pc_w, if3.alu_out_w, if3.a3_w, if3.dm_read_w, if3.exc_w);
            end
        end
        if (if3.we_pulse === 1'b1) begin
            if (sq3.size() == 0) unexpected("u3_we_pulse");
            else begin
                se3 = sq3.pop_front();
                cmp_s("u3", se3, if3.w_addr, if3.w_data, if3.w_byte_en, if3.w_pc);
            end
        end
    end

    always @(negedge clk) begin
        if (if4.valid_w === 1'b1) begin
            if (wq4.size() == 0) unexpected("u4_valid_w");
            else begin
                we4 = wq4.pop_front();
                cmp_w("u4", we4, if4.instr_w, if4.pc_w, if4.alu_out_w, if4.a3_w, if4.dm_read_w, if4.exc_w);
            end
        end
        if (if4.we_pulse === 1'b1) begin
            if (sq4.size() == 0) unexpected("u4_we_pulse");
            else begin
                se4 = sq4.pop_front();
                cmp_s("u4", se4, if4.w_addr, if4.w_data, if4.w_byte_en, if4.w_pc);
            end
        end
    end

    task automatic set_m(input int which, input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] a3, input logic [31:0] alu, input logic [31:0] fwd);
        case (which)
            1: begin if1.valid_m = v; if1.instr_m = instr; if1.pc_m = pc; if1.a3_m = a3; if1.alu_out_m = alu; if1.fwd_m = fwd; end
            3: begin if3.valid_m = v; if3.instr_m = instr; if3.pc_m = pc; if3.a3_m = a3; if3.alu_out_m = alu; if3.fwd_m = fwd; end
            default: begin if4.valid_m = v; if4.instr_m = instr; if4.pc_m = pc; if4.a3_m = a3; if4.alu_out_m = alu; if4.fwd_m = fwd; end
        endcase
    endtask

    function automatic logic get_stall(input int which);
        case (which)
            1:       return if1.stall_m;
            3:       return if3.stall_m;
            default: return if4.stall_m;
        endcase
    endfunction

    // Issue one instruction at a negedge, hold it through the stall, return at the negedge after completion.
    task automatic op(input int which, input logic [5:0] opc, input logic [31:0] addr,
                      input logic [31:0] fwd, input logic [31:0] pc, input logic [4:0] a3,
                      input int exp_stall, input logic [4:0] exp_exc, input logic [31:0] exp_dm,
                      input logic [3:0] exp_be, input logic [31:0] exp_word);
        wexp_t w;
        sexp_t s;
        int n;
        w.instr = {opc, 10'd0, addr[15:0]};
        w.pc    = pc;
        w.alu   = addr;
        w.a3    = (exp_exc != 5'd0) ? 5'd0 : a3;
        w.dm    = exp_dm;
        w.exc   = exp_exc;
        s.addr  = {addr[31:2], 2'b00};
        s.data  = exp_word;
        s.be    = exp_be;
        s.pc    = pc;
        case (which)
            1:       begin wq1.push_back(w); if (exp_be != 4'd0) sq1.push_back(s); end
            3:       begin wq3.push_back(w); if (exp_be != 4'd0) sq3.push_back(s); end
            default: begin wq4.push_back(w); if (exp_be != 4'd0) sq4.push_back(s); end
        endcase
        set_m(which, 1'b1, w.instr, pc, a3, addr, fwd);
        #1;
        n = 0;
        while (get_stall(which) === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk($sformatf("u%0d_stall_cycles_pc%h", which, pc), n, exp_stall);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        set_m(1, 1'b0, 0, 0, 0, 0, 0);
        set_m(3, 1'b0, 0, 0, 0, 0, 0);
        set_m(4, 1'b0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_valid_w", {31'd0, if1.valid_w}, 32'd0);
        chk("rst_dm_read_w", if1.dm_read_w, 32'd0);
        chk("rst_exc_w", {27'd0, if1.exc_w}, 32'd0);
        chk("rst_we_pulse", {31'd0, if1.we_pulse}, 32'd0);
        chk("rst_w_addr", if1.w_addr, 32'd0);
        chk("rst_w_data", if1.w_data, 32'd0);
        chk("rst_stall_m", {31'd0, if4.stall_m}, 32'd0);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        // LAT = 1: whole byte/half/word matrix plus faults.
        op(1, LW,  32'h20, 32'h0,        32'h0FC, 5'd7, 0, 5'd0, 32'h00000000, 4'b0000, 32'h0);
        op(1, SW,  32'h10, 32'h12345678, 32'h100, 5'd0, 0, 5'd0, 32'h0,        4'b1111, 32'h12345678);
        op(1, LW,  32'h10, 32'h0,        32'h104, 5'd8, 0, 5'd0, 32'h12345678, 4'b0000, 32'h0);
        op(1, SB,  32'h13, 32'h555555AB, 32'h108, 5'd0, 0, 5'd0, 32'h0,        4'b1000, 32'hAB345678);
        op(1, LB,  32'h13, 32'h0,        32'h10C, 5'd9, 0, 5'd0, 32'hFFFFFFAB, 4'b0000, 32'h0);
        op(1, LBU, 32'h13, 32'h0,        32'h110, 5'd9, 0, 5'd0, 32'h000000AB, 4'b0000, 32'h0);
        op(1, SB,  32'h11, 32'h000000CD, 32'h114, 5'd0, 0, 5'd0, 32'h0,        4'b0010, 32'hAB34CD78);
        op(1, LW,  32'h10, 32'h0,        32'h118, 5'd3, 0, 5'd0, 32'hAB34CD78, 4'b0000, 32'h0);
        op(1, LB,  32'h11, 32'h0,        32'h11C, 5'd4, 0, 5'd0, 32'hFFFFFFCD, 4'b0000, 32'h0);
        op(1, SH,  32'h16, 32'h12348001, 32'h120, 5'd0, 0, 5'd0, 32'h0,        4'b1100, 32'h80010000);
        op(1, LH,  32'h16, 32'h0,        32'h124, 5'd5, 0, 5'd0, 32'hFFFF8001, 4'b0000, 32'h0);
        op(1, LHU, 32'h16, 32'h0,        32'h128, 5'd5, 0, 5'd0, 32'h00008001, 4'b0000, 32'h0);
        op(1, LW,  32'h14, 32'h0,        32'h12C, 5'd6, 0, 5'd0, 32'h80010000, 4'b0000, 32'h0);
        op(1, LW,  32'h21, 32'h0,        32'h130, 5'd10, 0, 5'd4, 32'h0,       4'b0000, 32'h0);
        op(1, SH,  32'h03, 32'hFFFF,     32'h134, 5'd0, 0, 5'd5, 32'h0,        4'b0000, 32'h0);
        op(1, SW,  32'h4000, 32'h1,      32'h138, 5'd0, 0, 5'd5, 32'h0,        4'b0000, 32'h0);
        op(1, LH,  32'h10, 32'h0,        32'h13C, 5'd11, 0, 5'd0, 32'hFFFFCD78, 4'b0000, 32'h0);
        op(1, ALU, 32'h55, 32'h0,        32'h140, 5'd2, 0, 5'd0, 32'h0,        4'b0000, 32'h0);
        set_m(1, 1'b0, 0, 0, 0, 0, 0);

        // LAT = 3: two stall cycles per memory op, none for ALU ops.
        op(3, SW,  32'h40, 32'hDEADBEEF, 32'h200, 5'd0, 2, 5'd0, 32'h0,        4'b1111, 32'hDEADBEEF);
        op(3, LW,  32'h40, 32'h0,        32'h204, 5'd12, 2, 5'd0, 32'hDEADBEEF, 4'b0000, 32'h0);
        op(3, ALU, 32'h77, 32'h0,        32'h208, 5'd13, 0, 5'd0, 32'h0,       4'b0000, 32'h0);
        op(3, LW,  32'h42, 32'h0,        32'h20C, 5'd14, 0, 5'd4, 32'h0,       4'b0000, 32'h0);
        set_m(3, 1'b0, 0, 0, 0, 0, 0);

        // LAT = 4: reset in the second cycle of a store discards it.
        set_m(4, 1'b1, {SW, 10'd0, 16'h0008}, 32'h300, 5'd0, 32'h8, 32'hCAFEF00D);
        #1;
        chk("u4_stall_cycle1", {31'd0, if4.stall_m}, 32'd1);
        @(negedge clk);
        #2;
        rst4_n = 1'b0;
        #1;
        chk("u4_stall_after_reset", {31'd0, if4.stall_m}, 32'd0);
        set_m(4, 1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst4_n = 1'b1;
            chk($sformatf("u4_no_we_pulse_%0d", i), {31'd0, if4.we_pulse}, 32'd0);
        end
        op(4, LW, 32'h8, 32'h0, 32'h304, 5'd15, 3, 5'd0, 32'h00000000, 4'b0000, 32'h0);
        set_m(4, 1'b0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("u1_pending_w", wq1.size(), 0);
        chk("u1_pending_store", sq1.size(), 0);
        chk("u3_pending_w", wq3.size(), 0);
        chk("u3_pending_store", sq3.size(), 0);
        chk("u4_pending_w", wq4.size(), 0);
        chk("u4_pending_store", sq4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
